// File: rtl/ex_stage_pipe_pkg.sv
// ex_stage_pipe_pkg: shared pipeline definitions for the execute stage.
//   - ALU operation codes (4 bits)
//   - forwarding select codes (2 bits)
//   - default datapath and register-index widths
// Optional feature macro used by ex_stage_pipe: EX_OVERFLOW_TRAP_EN.
package ex_stage_pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/ex_stage_pipe_alu_core.sv
// alu_core: purely combinational ALU for the execute stage.
//   a, b      in  DATA_W  operands
//   op        in  4       operation code (see ex_stage_pipe_pkg)
//   result    out DATA_W  result, modulo 2^DATA_W; 0 for unknown codes
//   overflow  out 1       signed overflow, ADD/SUB only
module alu_core
    import ex_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              less;

    assign sum  = a + b;
    assign diff = a - b;
    assign less = $signed(a) < $signed(b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_XOR: result = a ^ b;
            ALU_SUB: begin
                result   = diff;
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, less};
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_NOR: result = ~(a | b);
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage of a 5-stage MIPS pipeline.
// Selects ALU operands through the forwarding muxes, runs the ALU and
// registers result plus controls into the EX/MEM pipeline register.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   stall, flush, in_valid      hold / bubble / ID/EX-valid controls
//   forward_a, forward_b        operand forwarding selects
//   rs_data, rt_data, imm       register-file operands and immediate
//   alu_src, alu_op             operand-B select and ALU operation
//   mem_read, mem_write,
//   reg_write, dest_reg         controls carried to EX/MEM
//   exmem_result, memwb_data    forwarded values
//   ex_*                        registered EX/MEM outputs
// Macro EX_OVERFLOW_TRAP_EN: when defined, a signed-overflowing ADD/SUB has
// its side-effect controls (reg_write, mem_read, mem_write) suppressed.
module ex_stage_pipe
    import ex_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [3:0]        alu_op,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_alu_result,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_zero,
    output logic              ex_overflow
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;
    logic              mem_read_d;
    logic              mem_write_d;
    logic              reg_write_d;

    // Reserved select 2'b11 falls back to register-file data.
    always_comb begin
        op_a = rs_data;
        case (forward_a)
            FWD_EXMEM: op_a = exmem_result;
            FWD_MEMWB: op_a = memwb_data;
            default:   op_a = rs_data;
        endcase
    end

    always_comb begin
        fwd_b = rt_data;
        case (forward_b)
            FWD_EXMEM: fwd_b = exmem_result;
            FWD_MEMWB: fwd_b = memwb_data;
            default:   fwd_b = rt_data;
        endcase
    end

    assign op_b = alu_src ? imm : fwd_b;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .a        (op_a),
        .b        (op_b),
        .op       (alu_op),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    // alu_overflow is only ever set for ADD/SUB, so it alone qualifies the trap.
    always_comb begin
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        reg_write_d = reg_write;
`ifdef EX_OVERFLOW_TRAP_EN
        if (alu_overflow) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
        end
`else
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        reg_write_d = reg_write;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_alu_result <= '0;
            ex_store_data <= '0;
            ex_dest_reg   <= '0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_zero       <= 1'b0;
            ex_overflow   <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            // Bubble: flush beats stall; an idle ID/EX also loads a bubble.
            ex_valid      <= 1'b0;
            ex_alu_result <= '0;
            ex_store_data <= '0;
            ex_dest_reg   <= '0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_zero       <= 1'b0;
            ex_overflow   <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_alu_result <= alu_result;
            ex_store_data <= fwd_b;
            ex_dest_reg   <= dest_reg;
            ex_mem_read   <= mem_read_d;
            ex_mem_write  <= mem_write_d;
            ex_reg_write  <= reg_write_d;
            ex_zero       <= (alu_result == '0);
            ex_overflow   <= alu_overflow;
        end
    end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ForwardA/ForwardB selects from the forwarding unit and selects the ALU operands from three sources: register file, EX/MEM result, or MEM/WB write-back data.
- Performs the ALU operation and registers the result and control signals into the EX/MEM pipeline register.
- Supports stall, flush and bubble insertion.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold EX/MEM register contents.
- flush  in  1  load a bubble into EX/MEM next edge.
- in_valid  in  1  ID/EX holds a real instruction.
- forward_a  in  2  operand-A select from forwarding unit.
- forward_b  in  2  operand-B select from forwarding unit.
- rs_data  in  DATA_W  register-file rs value.
- rt_data  in  DATA_W  register-file rt value.
- imm  in  DATA_W  sign-extended immediate.
- alu_src  in  1  1 = operand B is imm.
- alu_op  in  4  ALU operation code.
- mem_read  in  1  lw control.
- mem_write  in  1  sw control.
- reg_write  in  1  write-back enable.
- dest_reg  in  REG_AW  destination register (rd or rt, already resolved).
- exmem_result  in  DATA_W  forwarded EX/MEM ALU result.
- memwb_data  in  DATA_W  forwarded MEM/WB write-back value.
- ex_valid  out  1  EX/MEM holds a real instruction.
- ex_alu_result  out  DATA_W  registered ALU result.
- ex_store_data  out  DATA_W  registered forwarded rt value, for sw.
- ex_dest_reg  out  REG_AW  registered destination.
- ex_mem_read  out  1  registered control.
- ex_mem_write  out  1  registered control.
- ex_reg_write  out  1  registered control.
- ex_zero  out  1  registered (alu result == 0).
- ex_overflow  out  1  registered signed-overflow flag.

Behaviour:

Operand selection (combinational):
- Forward select decode: 00 = rf data, 01 = exmem_result, 10 = memwb_data, 11 = reserved, treated as 00.
- opA = forward_a mux over rs_data.
- fwdB = forward_b mux over rt_data.
- opB = alu_src ? imm : fwdB.
- Store data is always fwdB, never imm.

ALU (alu_op):
- 0000 AND.
- 0001 OR.
- 0010 ADD.
- 0011 XOR.
- 0110 SUB.
- 0111 SLT, signed; result is 1 or 0.
- 1000 SLL, opA << opB[4:0].
- 1001 SRL, logical.
- 1100 NOR.
- All other codes: result 0, overflow 0.
- Arithmetic is modulo 2^DATA_W.
- Overflow flag is computed for ADD/SUB only: operand signs equal (ADD) or differ (SUB) and the result sign differs from opA's sign.

Register update, evaluated on rising clk, in priority order:
1. rst_n low, asynchronous: every output is 0, immediately and regardless of clk.
2. flush: bubble loaded. ex_valid, ex_mem_read, ex_mem_write and ex_reg_write are 0. Data outputs are 0. flush beats stall.
3. stall: all outputs hold their values.
4. in_valid = 0: bubble loaded, same as flush.
5. Otherwise: load result, fwdB, dest_reg and the controls; ex_valid = 1.

Other rules:
- Latency: exactly 1 cycle from ID/EX inputs to EX/MEM outputs. Throughput: 1 instruction per cycle.
- dest_reg = 0 with reg_write = 1 is passed through unchanged. Suppression of $0 writes belongs to write-back and the forwarding unit.
- Reset released mid-stream: the first edge after deassertion samples the inputs normally. No extra bubble is inserted.
- stall and flush together: flush wins.

Optional Feature:
- Macro: EX_OVERFLOW_TRAP_EN.
- Defined: a valid ADD/SUB with signed overflow loads ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0 and ex_overflow = 1. ex_alu_result still holds the wrapped sum. ex_valid = 1.
- Undefined: ex_overflow is still reported, but the controls pass unmodified.

Decomposition:
- Shared package/header (pipeline defines): alu_op codes, forward-select codes FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10, and DATA_W/REG_AW defaults.
- Sub-module: alu_core, purely combinational, with inputs a, b, op and outputs result, overflow.
- ex_stage_pipe owns the forwarding muxes and the EX/MEM register.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle with inputs active. All outputs go to 0 immediately. After release, ADD rs_data = 5, rt_data = 7 -> ex_alu_result = 12, ex_valid = 1, one edge later.
- Forwarding: forward_a = 01, exmem_result = 100, rs_data = 1, rt_data = 3, ADD -> 103. Then forward_b = 10, memwb_data = 50, SUB with forward_a = 00, rs_data = 60 -> 10, ex_zero = 0. Then forward_a = 11 -> rs_data is used.
- sw store data: alu_src = 1, imm = 8, forward_b = 01, exmem_result = 0xDEAD, mem_write = 1 -> ex_store_data = 0xDEAD, ex_alu_result = rs + 8.
- Stall/flush: stall for 3 cycles -> outputs frozen. stall = flush = 1 -> bubble (ex_valid = 0, controls 0). in_valid = 0 -> bubble.
- Overflow: ADD 0x7FFFFFFF + 1 with reg_write = 1 -> ex_alu_result = 0x80000000, ex_overflow = 1. ex_reg_write = 0 with EX_OVERFLOW_TRAP_EN, 1 without.
- ALU sweep: SLT -1 vs 1 -> 1. SLL 1 by 31 -> 0x80000000. SRL 0x80000000 by 31 -> 1. NOR 0, 0 -> 0xFFFFFFFF. Illegal op 1111 -> 0 with ex_zero = 1.
